// File: rtl/spu_dual_issue_unit.sv
// Issue stage for the dual-issue SPU-lite core: steers decoded pairs to the even/odd pipes,
// splits hazarding pairs over two cycles. Optional issue counters under `ISSUE_STATS_EN.
module spu_dual_issue_unit #(
  parameter int REG_AW = 7,
  parameter int IMM_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op0,
  input  logic [6:0]        op1,
  input  logic [REG_AW-1:0] rt0,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] rb0,
  input  logic [REG_AW-1:0] rc0,
  input  logic [REG_AW-1:0] rt1,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] rb1,
  input  logic [REG_AW-1:0] rc1,
  input  logic [2:0]        src_v0,
  input  logic [2:0]        src_v1,
  input  logic              wr_v0,
  input  logic              wr_v1,
  input  logic [IMM_W-1:0]  imm0,
  input  logic [IMM_W-1:0]  imm1,
  input  logic              stall,
  input  logic              flush,
  output logic              even_valid,
  output logic              odd_valid,
  output logic [6:0]        even_op,
  output logic [6:0]        odd_op,
  output logic [REG_AW-1:0] even_rt,
  output logic [REG_AW-1:0] even_ra,
  output logic [REG_AW-1:0] even_rb,
  output logic [REG_AW-1:0] even_rc,
  output logic [REG_AW-1:0] odd_rt,
  output logic [REG_AW-1:0] odd_ra,
  output logic [REG_AW-1:0] odd_rb,
  output logic [REG_AW-1:0] odd_rc,
  output logic              even_wr_v,
  output logic              odd_wr_v,
  output logic [IMM_W-1:0]  even_imm,
  output logic [IMM_W-1:0]  odd_imm,
  output logic              halted,
  output logic              illegal
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]       dual_cnt,
  output logic [31:0]       single_cnt
`endif
);

  localparam logic [6:0] OP_STOP = 7'd92;
  localparam logic [6:0] OP_NOPX = 7'd93;

  typedef enum logic {RUN, SPLIT} state_t;

  typedef struct packed {
    logic [6:0]        op;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic              wr_v;
    logic [IMM_W-1:0]  imm;
  } slot_t;

  function automatic logic is_illegal(input logic [6:0] op);
    return (op == 7'd0) || (op == 7'd8) || (op >= 7'd95);
  endfunction

  function automatic logic is_odd(input logic [6:0] op);
    return ((op >= 7'd67) && (op <= 7'd92)) || (op == 7'd94);
  endfunction

  state_t     state;
  slot_t      even_q, odd_q, hold;
  logic       hold_odd;
  slot_t      s0, s1;
  logic       ill0, ill1, odd0, odd1, stop0, stop1;
  logic [2:0] src1;
  logic       raw, waw, conflict, accept;

  // slot0's source bits never matter: it is always the older instruction.
  logic unused_src0;
  assign unused_src0 = ^src_v0;

  // Illegal opcodes become a non-writing no-op and classify as even.
  always_comb begin
    ill0     = is_illegal(op0);
    ill1     = is_illegal(op1);
    odd0     = is_odd(op0);
    odd1     = is_odd(op1);
    stop0    = (op0 == OP_STOP);
    stop1    = (op1 == OP_STOP);
    s0.op    = ill0 ? OP_NOPX : op0;
    s0.rt    = rt0;
    s0.ra    = ra0;
    s0.rb    = rb0;
    s0.rc    = rc0;
    s0.wr_v  = wr_v0 && !ill0;
    s0.imm   = imm0;
    s1.op    = ill1 ? OP_NOPX : op1;
    s1.rt    = rt1;
    s1.ra    = ra1;
    s1.rb    = rb1;
    s1.rc    = rc1;
    s1.wr_v  = wr_v1 && !ill1;
    s1.imm   = imm1;
    src1     = ill1 ? 3'b000 : src_v1;
    raw      = s0.wr_v && ((src1[2] && (ra1 == rt0)) ||
                           (src1[1] && (rb1 == rt0)) ||
                           (src1[0] && (rc1 == rt0)));
    waw      = s0.wr_v && s1.wr_v && (rt0 == rt1);
    conflict = (odd0 == odd1) || raw || waw;
  end

  assign in_ready = (state == RUN) && !stall && !halted && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      even_q     <= '0;
      odd_q      <= '0;
      hold       <= '0;
      hold_odd   <= 1'b0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      hold       <= '0;
      hold_odd   <= 1'b0;
      state      <= RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if (accept) begin
            even_valid <= !odd0 || (!stop0 && !conflict && !odd1);
            odd_valid  <= odd0 || (!stop0 && !conflict && odd1);
            if (odd0) odd_q <= s0;
            else      even_q <= s0;
            if (stop0) begin
              halted  <= 1'b1;
              illegal <= illegal | ill0;
            end else if (conflict) begin
              hold     <= s1;
              hold_odd <= odd1;
              state    <= SPLIT;
              illegal  <= illegal | ill0 | ill1;
            end else begin
              if (odd1) odd_q <= s1;
              else      even_q <= s1;
              if (stop1) halted <= 1'b1;
              illegal <= illegal | ill0 | ill1;
            end
          end else begin
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
          end
        end
        SPLIT: begin
          even_valid <= !hold_odd;
          odd_valid  <= hold_odd;
          if (hold_odd) odd_q <= hold;
          else          even_q <= hold;
          if (hold.op == OP_STOP) halted <= 1'b1;
          hold     <= '0;
          hold_odd <= 1'b0;
          state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
    end else if (!flush && !stall) begin
      if (state == SPLIT)
        single_cnt <= single_cnt + 32'd1;
      else if (accept) begin
        if (stop0 || conflict) single_cnt <= single_cnt + 32'd1;
        else                   dual_cnt   <= dual_cnt + 32'd1;
      end
    end
  end
`endif

  assign even_op   = even_q.op;
  assign even_rt   = even_q.rt;
  assign even_ra   = even_q.ra;
  assign even_rb   = even_q.rb;
  assign even_rc   = even_q.rc;
  assign even_wr_v = even_q.wr_v;
  assign even_imm  = even_q.imm;
  assign odd_op    = odd_q.op;
  assign odd_rt    = odd_q.rt;
  assign odd_ra    = odd_q.ra;
  assign odd_rb    = odd_q.rb;
  assign odd_rc    = odd_q.rc;
  assign odd_wr_v  = odd_q.wr_v;
  assign odd_imm   = odd_q.imm;

endmodule

// File: tb/tb_spu_dual_issue_unit.sv
// Directed scoreboard bench for spu_dual_issue_unit: expected issues are queued as pairs are driven.
module tb_spu_dual_issue_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [6:0] op0, op1;
  logic [6:0] rt0, ra0, rb0, rc0, rt1, ra1, rb1, rc1;
  logic [2:0] src_v0, src_v1;
  logic       wr_v0, wr_v1;
  logic [17:0] imm0, imm1;
  logic       stall, flush;
  logic       even_valid, odd_valid;
  logic [6:0] even_op, odd_op;
  logic [6:0] even_rt, even_ra, even_rb, even_rc, odd_rt, odd_ra, odd_rb, odd_rc;
  logic       even_wr_v, odd_wr_v;
  logic [17:0] even_imm, odd_imm;
  logic       halted, illegal;
`ifdef ISSUE_STATS_EN
  logic [31:0] dual_cnt, single_cnt;
  logic [31:0] d0, s0c;
`endif

  spu_dual_issue_unit #(.REG_AW(7), .IMM_W(18)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op0(op0), .op1(op1),
    .rt0(rt0), .ra0(ra0), .rb0(rb0), .rc0(rc0),
    .rt1(rt1), .ra1(ra1), .rb1(rb1), .rc1(rc1),
    .src_v0(src_v0), .src_v1(src_v1), .wr_v0(wr_v0), .wr_v1(wr_v1),
    .imm0(imm0), .imm1(imm1), .stall(stall), .flush(flush),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_op(even_op), .odd_op(odd_op),
    .even_rt(even_rt), .even_ra(even_ra), .even_rb(even_rb), .even_rc(even_rc),
    .odd_rt(odd_rt), .odd_ra(odd_ra), .odd_rb(odd_rb), .odd_rc(odd_rc),
    .even_wr_v(even_wr_v), .odd_wr_v(odd_wr_v),
    .even_imm(even_imm), .odd_imm(odd_imm),
    .halted(halted), .illegal(illegal)
`ifdef ISSUE_STATS_EN
    , .dual_cnt(dual_cnt), .single_cnt(single_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ev;
    logic [6:0]  eop;
    logic [6:0]  ert;
    logic        ewr;
    logic [17:0] eimm;
    bit          ov;
    logic [6:0]  oop;
    logic [6:0]  ort;
    logic        owr;
    logic [17:0] oimm;
  } exp_t;

  exp_t q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit ev, input logic [6:0] eop, input logic [6:0] ert, input logic ewr,
                      input logic [17:0] eimm, input bit ov, input logic [6:0] oop,
                      input logic [6:0] ort, input logic owr, input logic [17:0] oimm);
    exp_t e;
    e.ev = ev; e.eop = eop; e.ert = ert; e.ewr = ewr; e.eimm = eimm;
    e.ov = ov; e.oop = oop; e.ort = ort; e.owr = owr; e.oimm = oimm;
    q.push_back(e);
  endtask

  task automatic expect_issue(input string tag);
    exp_t e;
    chk({tag, "_sb_avail"}, (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_even_valid"}, {31'd0, even_valid}, {31'd0, e.ev});
      chk({tag, "_odd_valid"}, {31'd0, odd_valid}, {31'd0, e.ov});
      if (e.ev) begin
        chk({tag, "_even_op"}, {25'd0, even_op}, {25'd0, e.eop});
        chk({tag, "_even_rt"}, {25'd0, even_rt}, {25'd0, e.ert});
        chk({tag, "_even_wr"}, {31'd0, even_wr_v}, {31'd0, e.ewr});
        chk({tag, "_even_imm"}, {14'd0, even_imm}, {14'd0, e.eimm});
      end
      if (e.ov) begin
        chk({tag, "_odd_op"}, {25'd0, odd_op}, {25'd0, e.oop});
        chk({tag, "_odd_rt"}, {25'd0, odd_rt}, {25'd0, e.ort});
        chk({tag, "_odd_wr"}, {31'd0, odd_wr_v}, {31'd0, e.owr});
        chk({tag, "_odd_imm"}, {14'd0, odd_imm}, {14'd0, e.oimm});
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_even_idle"}, {31'd0, even_valid}, 32'd0);
    chk({tag, "_odd_idle"}, {31'd0, odd_valid}, 32'd0);
  endtask

  task automatic drive(input logic [6:0] o0, input logic [6:0] t0, input logic w0,
                       input logic [6:0] o1, input logic [6:0] t1, input logic [6:0] a1,
                       input logic [2:0] s1, input logic w1);
    in_valid = 1'b1;
    op0 = o0; rt0 = t0; wr_v0 = w0; ra0 = '0; rb0 = '0; rc0 = '0; src_v0 = 3'b000;
    op1 = o1; rt1 = t1; ra1 = a1; rb1 = '0; rc1 = '0; src_v1 = s1; wr_v1 = w1;
    imm0 = 18'h01000 | {11'd0, o0};
    imm1 = 18'h02000 | {11'd0, o1};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    op0 = '0; op1 = '0; rt0 = '0; ra0 = '0; rb0 = '0; rc0 = '0;
    rt1 = '0; ra1 = '0; rb1 = '0; rc1 = '0; src_v0 = '0; src_v1 = '0;
    wr_v0 = 1'b0; wr_v1 = 1'b0; imm0 = '0; imm1 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_idle("reset");
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_even_op", {25'd0, even_op}, 32'd0);
    chk("reset_odd_rt", {25'd0, odd_rt}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ISSUE_STATS_EN
    chk("reset_dual", dual_cnt, 32'd0);
    chk("reset_single", single_cnt, 32'd0);
`endif

    // No-conflict pair: even ADD_WORD, odd load
    drive(7'd1, 7'd5, 1'b1, 7'd80, 7'd10, 7'd9, 3'b100, 1'b1);
    push(1, 7'd1, 7'd5, 1'b1, 18'h01001, 1, 7'd80, 7'd10, 1'b1, 18'h02050);
    cyc(); in_valid = 1'b0;
    expect_issue("dual");
    cyc(); expect_idle("dual_after");

    // RAW on rt0 forces a split
    drive(7'd1, 7'd5, 1'b1, 7'd81, 7'd11, 7'd5, 3'b100, 1'b1);
    push(1, 7'd1, 7'd5, 1'b1, 18'h01001, 0, '0, '0, 1'b0, '0);
    push(0, '0, '0, 1'b0, '0, 1, 7'd81, 7'd11, 1'b1, 18'h02051);
    cyc(); in_valid = 1'b0;
    expect_issue("raw_c1");
    chk("raw_split_ready", {31'd0, in_ready}, 32'd0);
    cyc(); expect_issue("raw_c2");
    chk("raw_ready_back", {31'd0, in_ready}, 32'd1);
    cyc(); expect_idle("raw_after");

    // Same-pipe split
`ifdef ISSUE_STATS_EN
    d0 = dual_cnt; s0c = single_cnt;
`endif
    drive(7'd13, 7'd20, 1'b1, 7'd57, 7'd21, 7'd0, 3'b000, 1'b1);
    push(1, 7'd13, 7'd20, 1'b1, 18'h0100d, 0, '0, '0, 1'b0, '0);
    push(1, 7'd57, 7'd21, 1'b1, 18'h02039, 0, '0, '0, 1'b0, '0);
    cyc(); in_valid = 1'b0;
    expect_issue("same_c1");
    cyc(); expect_issue("same_c2");
    cyc(); expect_idle("same_after");
`ifdef ISSUE_STATS_EN
    chk("same_dual_delta", dual_cnt - d0, 32'd0);
    chk("same_single_delta", single_cnt - s0c, 32'd2);
`endif

    // Stall during SPLIT freezes outputs; flush then drops the held slot
    drive(7'd2, 7'd30, 1'b1, 7'd3, 7'd31, 7'd0, 3'b000, 1'b1);
    push(1, 7'd2, 7'd30, 1'b1, 18'h01002, 0, '0, '0, 1'b0, '0);
    cyc(); in_valid = 1'b0;
    expect_issue("stall_c1");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_even_valid", {31'd0, even_valid}, 32'd1);
      chk("stall_even_op", {25'd0, even_op}, 32'd2);
      chk("stall_even_rt", {25'd0, even_rt}, 32'd30);
      chk("stall_odd_valid", {31'd0, odd_valid}, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(); flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    expect_idle("flush");
    cyc(); expect_idle("flush_no_held");
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    cyc(); expect_idle("flush_no_held2");

    // Illegal opcode becomes a non-writing 93 on even; odd partner still issues
    drive(7'd8, 7'd40, 1'b1, 7'd70, 7'd41, 7'd0, 3'b000, 1'b1);
    push(1, 7'd93, 7'd40, 1'b0, 18'h01008, 1, 7'd70, 7'd41, 1'b1, 18'h02046);
    cyc(); in_valid = 1'b0;
    expect_issue("illegal");
    chk("illegal_flag", {31'd0, illegal}, 32'd1);
    cyc(); cyc();
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("async_rst_even_op", {25'd0, even_op}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // STOP in slot1: both issue, then halted
    drive(7'd1, 7'd60, 1'b1, 7'd92, 7'd61, 7'd0, 3'b000, 1'b0);
    push(1, 7'd1, 7'd60, 1'b1, 18'h01001, 1, 7'd92, 7'd61, 1'b0, 18'h0205c);
    cyc(); in_valid = 1'b0;
    expect_issue("stop1");
    cyc();
    chk("stop1_halted", {31'd0, halted}, 32'd1);
    expect_idle("stop1_after");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_clears_halt", {31'd0, halted}, 32'd0);

    // STOP in slot0: slot1 discarded, halt is sticky through flush
    drive(7'd92, 7'd50, 1'b0, 7'd1, 7'd51, 7'd0, 3'b000, 1'b1);
    push(0, '0, '0, 1'b0, '0, 1, 7'd92, 7'd50, 1'b0, 18'h0105c);
    cyc(); in_valid = 1'b0;
    expect_issue("stop0");
    chk("stop0_halted", {31'd0, halted}, 32'd1);
    drive(7'd1, 7'd3, 1'b1, 7'd80, 7'd4, 7'd0, 3'b000, 1'b1);
    chk("halt_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(); expect_idle("halt_idle");
    flush = 1'b1;
    cyc(); flush = 1'b0;
    cyc();
    chk("halt_after_flush", {31'd0, halted}, 32'd1);
    chk("halt_ready_after_flush", {31'd0, in_ready}, 32'd0);
    expect_idle("halt_idle2");
    in_valid = 1'b0;
    chk("sb_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
